main_ctrl_fsm: RTL

Multi-cycle main control unit for the MIPS datapath. It decodes the instruction opcode and sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select, and the 3-bit `alu_op` consumed directly by the ALU control stage. It sits between the instruction register and the datapath, and stalls on memory via a ready handshake.

---
 rtl/main_ctrl_fsm.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle MIPS main control unit.
// Sequences each instruction through fetch, decode, execute, memory and
// write-back states and drives every datapath enable and mux select.
// All outputs are decoded from the state register; only the FETCH
// ir_write/pc_write strobes are additionally qualified by mem_ready so the
// IR and PC load exactly on the cycle memory delivers the instruction.
module main_ctrl_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state_r;
  logic   illegal_r;

  // State sequencing and the sticky illegal-opcode flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_FETCH;
      illegal_r <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (mem_ready) state_r <= S_DECODE;
          else           state_r <= S_FETCH;
        end
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_r <= S_MEM_ADDR;
            OP_RTYPE:     state_r <= S_R_EXEC;
            OP_BEQ:       state_r <= S_BRANCH;
            OP_J:         state_r <= S_JUMP;
            OP_ADDI:      state_r <= S_ADDI_EXEC;
            default: begin
              state_r   <= S_FETCH;
              illegal_r <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          // Opcode changing between DECODE and here is not a legal
          // program flow; recover by refetching.
          if (opcode == OP_LW)      state_r <= S_MEM_READ;
          else if (opcode == OP_SW) state_r <= S_MEM_WRITE;
          else                      state_r <= S_FETCH;
        end
        S_MEM_READ: begin
          if (mem_ready) state_r <= S_MEM_WB;
          else           state_r <= S_MEM_READ;
        end
        S_MEM_WRITE: begin
          if (mem_ready) state_r <= S_FETCH;
          else           state_r <= S_MEM_WRITE;
        end
        S_R_EXEC:    state_r <= S_R_WB;
        S_ADDI_EXEC: state_r <= S_ADDI_WB;
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_r <= S_FETCH;
        default:     state_r <= S_FETCH;
      endcase
    end
  end

  // Datapath control decode from the current state.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 3'd0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'd2;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDI_WB: reg_write = 1'b1;
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign state      = state_r;
  assign illegal_op = illegal_r;

endmodule
